mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/aww_types_pkg.sv | 12 +
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/aww_types_pkg.sv
// Arbiter-local types: grant FSM state encoding and the fairness threshold.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam logic [1:0] ARB_FAIR_LIMIT = 2'd3;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: 32-bit word and the RAM handshake state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data priority.
// Optional fairness counter enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iwait,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dwait,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       ram_done;
  logic       ram_err;
  logic       fair_pick_i;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS);
  assign ram_err  = (ramstate == ERROR);

`ifdef MEM_ARB_FAIR_EN
  logic [1:0] fair_cnt_q, fair_cnt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) fair_cnt_q <= '0;
    else       fair_cnt_q <= fair_cnt_d;
  end

  // Counts data completions that starved a pending fetch; saturates at the limit.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == IGRANT && ram_done)
      fair_cnt_d = '0;
    else if (state_q == DGRANT && ram_done && iREN && fair_cnt_q != ARB_FAIR_LIMIT)
      fair_cnt_d = fair_cnt_q + 2'd1;
  end

  assign fair_pick_i = iREN && (fair_cnt_q == ARB_FAIR_LIMIT);
`else
  assign fair_pick_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (fair_pick_i)  state_d = IGRANT;
        else if (d_req)   state_d = DGRANT;
        else if (iREN)    state_d = IGRANT;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN || ram_done || ram_err) state_d = IDLE;
      end
      DGRANT: begin
        // Write wins when both strobes are raised together.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req || ram_done || ram_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iwait = iREN  & ~(state_q == IGRANT && ram_done);
  assign dwait = d_req & ~(state_q == DGRANT && ram_done);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: driver queues expected outputs, negedge monitor compares.
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  typedef struct {
    int          id;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    logic        iw;
    logic        dw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // Monitor: the DUT presents a full set of outputs every cycle; compare at negedge.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (ramREN !== e.ren || ramWEN !== e.wen || ramaddr !== e.addr || ramstore !== e.store ||
          iload !== e.load || dload !== e.load || iwait !== e.iw || dwait !== e.dw) begin
        errors++;
        $display("FAIL step%0d: got ren=%b wen=%b addr=%h store=%h iload=%h dload=%h iwait=%b dwait=%b; want ren=%b wen=%b addr=%h store=%h load=%h iwait=%b dwait=%b",
                 e.id, ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait,
                 e.ren, e.wen, e.addr, e.store, e.load, e.iw, e.dw);
      end
    end
  end

  task automatic step(input logic nrst, input logic ir, input logic dr, input logic dw,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                      input logic [31:0] rl, input logic [1:0] rs,
                      input logic eren, input logic ewen, input logic [31:0] ea,
                      input logic [31:0] es, input logic eiw, input logic edw);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = nrst; iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    e.id = step_id; e.ren = eren; e.wen = ewen; e.addr = ea; e.store = es;
    e.load = rl; e.iw = eiw; e.dw = edw;
    exp_q.push_back(e);
    step_id++;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

    // Reset state
    step(0, 0,0,0, 32'h0,   32'h0,   32'h0,        32'h1234_5678, RS_FREE, 0,0, 32'h0,   32'h0,        0,0);
    // Instruction fetch, ACCESS on third grant cycle
    step(1, 1,0,0, 32'h40,  32'h0,   32'h0,        32'h0000_0001, RS_FREE, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h0,   32'h0,        32'h0000_0002, RS_BUSY, 1,0, 32'h40,  32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h0,   32'h0,        32'h0000_0003, RS_BUSY, 1,0, 32'h40,  32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h0,   32'h0,        32'h8C01_0004, RS_ACC,  1,0, 32'h40,  32'h0,        0,0);
    step(1, 0,0,0, 32'h40,  32'h0,   32'h0,        32'h0000_0005, RS_FREE, 0,0, 32'h0,   32'h0,        0,0);
    // Simultaneous fetch and write: data first, fetch after turnaround
    step(1, 1,0,1, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        1,1);
    step(1, 1,0,1, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'h0,        RS_BUSY, 0,1, 32'h100, 32'hDEAD_BEEF, 1,1);
    step(1, 1,0,1, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'h0,        RS_ACC,  0,1, 32'h100, 32'hDEAD_BEEF, 1,0);
    step(1, 1,0,0, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'hCAFE_0001, RS_ACC, 1,0, 32'h40,  32'h0,        0,0);
    step(1, 0,0,0, 32'h40,  32'h100, 32'hDEAD_BEEF, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,0);
    // ERROR during data grant: back to IDLE with dwait held, then re-grant
    step(1, 0,1,0, 32'h40,  32'h200, 32'h1111_2222, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,1);
    step(1, 0,1,0, 32'h40,  32'h200, 32'h1111_2222, 32'h0,        RS_ERR,  1,0, 32'h200, 32'h1111_2222, 0,1);
    step(1, 0,1,0, 32'h40,  32'h200, 32'h1111_2222, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,1);
    step(1, 0,1,0, 32'h40,  32'h200, 32'h1111_2222, 32'hBEEF_0002, RS_ACC, 1,0, 32'h200, 32'h1111_2222, 0,0);
    step(1, 0,0,0, 32'h40,  32'h200, 32'h1111_2222, 32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,0);
    // Fetch withdrawn mid-grant: still driven that cycle, then IDLE
    step(1, 1,0,0, 32'h40,  32'h0,   32'h0,        32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 0,0,0, 32'h40,  32'h0,   32'h0,        32'h0,        RS_BUSY, 1,0, 32'h40,  32'h0,        0,0);
    step(1, 0,0,0, 32'h40,  32'h0,   32'h0,        32'h0,        RS_BUSY, 0,0, 32'h0,   32'h0,        0,0);
    // Reset mid-grant, re-issue, then data held off until IDLE
    step(1, 1,0,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_BUSY, 1,0, 32'h40,  32'h0,        1,0);
    step(0, 1,0,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_BUSY, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 1,0,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_BUSY, 0,0, 32'h0,   32'h0,        1,0);
    step(1, 1,1,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_BUSY, 1,0, 32'h40,  32'h0,        1,1);
    step(1, 1,1,0, 32'h40,  32'h300, 32'h0,        32'h7777_0003, RS_ACC, 1,0, 32'h40,  32'h0,        0,1);
    step(1, 0,1,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,1);
    step(1, 0,1,0, 32'h40,  32'h300, 32'h0,        32'h6666_0004, RS_ACC, 1,0, 32'h300, 32'h0,        0,0);
    step(1, 0,0,0, 32'h40,  32'h300, 32'h0,        32'h0,        RS_FREE, 0,0, 32'h0,   32'h0,        0,0);
    // Fetch starved by continuous data reads
    for (int k = 0; k < 3; k++) begin
      step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'h0,           RS_ACC, 0,0, 32'h0,   32'h0, 1,1);
      step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'h5000_0000 + k, RS_ACC, 1,0, 32'h500, 32'h0, 1,0);
    end
    step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'h0, RS_ACC, 0,0, 32'h0, 32'h0, 1,1);
`ifdef MEM_ARB_FAIR_EN
    step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'hF00D_0001, RS_ACC, 1,0, 32'h40,  32'h0, 0,1);
`else
    step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'hF00D_0001, RS_ACC, 1,0, 32'h500, 32'h0, 1,0);
`endif
    step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'h0,         RS_ACC, 0,0, 32'h0,   32'h0, 1,1);
    step(1, 1,1,0, 32'h40, 32'h500, 32'h0, 32'hF00D_0002, RS_ACC, 1,0, 32'h500, 32'h0, 1,0);
    step(1, 0,0,0, 32'h40, 32'h500, 32'h0, 32'h0,         RS_FREE, 0,0, 32'h0,  32'h0, 0,0);

    repeat (3) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
